// File: rtl/wb_arbiter.sv
// wb_arbiter: merges ALU and load writebacks into an in-order queue that drives
// a single register-file write port, with forwarding of pending writes to the read ports.
module wb_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        mem_valid,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_data,
    output logic        ready,
    output logic        RegWriteEN,
    output logic [4:0]  WriteReg,
    output logic [31:0] WriteData,
    input  logic [4:0]  ReadReg1,
    input  logic [4:0]  ReadReg2,
    output logic        fwd1_valid,
    output logic [31:0] fwd1_data,
    output logic        fwd2_valid,
    output logic [31:0] fwd2_data,
    output logic        err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]    rdMem   [DEPTH];
    logic [31:0]   dataMem [DEPTH];
    logic [PW-1:0] wrPtr, rdPtr;
    logic [CW-1:0] count;
    logic          memAcc, aluAcc, drop;

    assign ready      = (CW'(DEPTH) - count) >= CW'(2);
    assign memAcc     = mem_valid && ready && mem_rd != 5'd0;
    assign aluAcc     = alu_valid && ready && alu_rd != 5'd0;
    assign drop       = !ready && ((mem_valid && mem_rd != 5'd0) || (alu_valid && alu_rd != 5'd0));
    assign RegWriteEN = count != '0;
    assign WriteReg   = RegWriteEN ? rdMem[rdPtr] : 5'd0;
    assign WriteData  = RegWriteEN ? dataMem[rdPtr] : 32'd0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            err   <= 1'b0;
        end else begin
            wrPtr <= wrPtr + PW'(memAcc) + PW'(aluAcc);
            rdPtr <= rdPtr + PW'(RegWriteEN);
            count <= count + CW'(memAcc) + CW'(aluAcc) - CW'(RegWriteEN);
            if (drop) err <= 1'b1;
        end
    end

    // mem is the older instruction, so it takes the lower slot when both land together
    always_ff @(posedge clk) begin
        if (memAcc) begin
            rdMem[wrPtr]   <= mem_rd;
            dataMem[wrPtr] <= mem_data;
        end
        if (aluAcc) begin
            rdMem[wrPtr + PW'(memAcc)]   <= alu_rd;
            dataMem[wrPtr + PW'(memAcc)] <= alu_data;
        end
    end

    // walk oldest to youngest so the youngest match overwrites earlier ones
    always_comb begin
        fwd1_valid = 1'b0;
        fwd1_data  = 32'd0;
        fwd2_valid = 1'b0;
        fwd2_data  = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count && ReadReg1 != 5'd0 && rdMem[rdPtr + PW'(i)] == ReadReg1) begin
                fwd1_valid = 1'b1;
                fwd1_data  = dataMem[rdPtr + PW'(i)];
            end
            if (CW'(i) < count && ReadReg2 != 5'd0 && rdMem[rdPtr + PW'(i)] == ReadReg2) begin
                fwd2_valid = 1'b1;
                fwd2_data  = dataMem[rdPtr + PW'(i)];
            end
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed vector table plus reset and wrap-around sequences for wb_arbiter.
module tb_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        alu_valid = 1'b0, mem_valid = 1'b0;
    logic [4:0]  alu_rd = 5'd0, mem_rd = 5'd0, ReadReg1 = 5'd0, ReadReg2 = 5'd0;
    logic [31:0] alu_data = 32'd0, mem_data = 32'd0;
    logic        ready, RegWriteEN, fwd1_valid, fwd2_valid, err;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData, fwd1_data, fwd2_data;
    int          checks = 0, errors = 0;

    wb_arbiter #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
        .ready(ready), .RegWriteEN(RegWriteEN), .WriteReg(WriteReg), .WriteData(WriteData),
        .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
        .fwd1_valid(fwd1_valid), .fwd1_data(fwd1_data),
        .fwd2_valid(fwd2_valid), .fwd2_data(fwd2_data),
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adat;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] mdat;
        logic [4:0]  r1, r2;
        logic        rdy, we;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic        f1v;
        logic [31:0] f1d;
        logic        f2v;
        logic [31:0] f2d;
        logic        e;
    } vec_t;

    vec_t vecs [14];

    function automatic logic [105:0] pk(input logic rdy, input logic we, input logic [4:0] wr,
                                        input logic [31:0] wd, input logic f1v, input logic [31:0] f1d,
                                        input logic f2v, input logic [31:0] f2d, input logic e);
        return {rdy, we, wr, wd, f1v, f1d, f2v, f2d, e};
    endfunction

    task automatic chk(input string nm, input logic [105:0] exp);
        logic [105:0] act;
        act = pk(ready, RegWriteEN, WriteReg, WriteData, fwd1_valid, fwd1_data, fwd2_valid, fwd2_data, err);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {rdy,we,wr,wd,f1v,f1d,f2v,f2d,err}=%h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] mdat,
                         input logic [4:0] r1, input logic [4:0] r2);
        alu_valid = av; alu_rd = ard; alu_data = adat;
        mem_valid = mv; mem_rd = mrd; mem_data = mdat;
        ReadReg1 = r1; ReadReg2 = r2;
    endtask

    initial begin
        // av ard adat mv mrd mdat r1 r2 | rdy we wr wd f1v f1d f2v f2d err
        vecs[0]  = '{1'b1, 5'd5, 32'hAA, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
        vecs[1]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 32'hAA, 1'b1, 32'hAA, 1'b1, 32'hAA, 1'b0};
        vecs[2]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
        vecs[3]  = '{1'b1, 5'd7, 32'h22, 1'b1, 5'd7, 32'h11, 5'd7, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
        vecs[4]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd0, 1'b1, 1'b1, 5'd7, 32'h11, 1'b1, 32'h22, 1'b0, 32'h0, 1'b0};
        vecs[5]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd0, 1'b1, 1'b1, 5'd7, 32'h22, 1'b1, 32'h22, 1'b0, 32'h0, 1'b0};
        vecs[6]  = '{1'b1, 5'd0, 32'h33, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
        vecs[7]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
        vecs[8]  = '{1'b1, 5'd2, 32'h102, 1'b1, 5'd1, 32'h101, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
        vecs[9]  = '{1'b1, 5'd4, 32'h104, 1'b1, 5'd3, 32'h103, 5'd0, 5'd0, 1'b1, 1'b1, 5'd1, 32'h101, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
        vecs[10] = '{1'b1, 5'd9, 32'h999, 1'b0, 5'd0, 32'h0, 5'd9, 5'd4, 1'b0, 1'b1, 5'd2, 32'h102, 1'b0, 32'h0, 1'b1, 32'h104, 1'b0};
        vecs[11] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd4, 1'b1, 1'b1, 5'd3, 32'h103, 1'b0, 32'h0, 1'b1, 32'h104, 1'b1};
        vecs[12] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd4, 1'b1, 1'b1, 5'd4, 32'h104, 1'b0, 32'h0, 1'b1, 32'h104, 1'b1};
        vecs[13] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1};

        @(negedge clk);
        #1 chk("reset_state", pk(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0));
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(vecs[i].av, vecs[i].ard, vecs[i].adat, vecs[i].mv, vecs[i].mrd, vecs[i].mdat, vecs[i].r1, vecs[i].r2);
            #1 chk($sformatf("vec%0d", i), pk(vecs[i].rdy, vecs[i].we, vecs[i].wr, vecs[i].wd,
                                              vecs[i].f1v, vecs[i].f1d, vecs[i].f2v, vecs[i].f2d, vecs[i].e));
        end

        // reset mid-drain: three entries queued, err still set from the drop above
        @(negedge clk);
        drive(1'b1, 5'd11, 32'hB, 1'b1, 5'd10, 32'hA, 5'd11, 5'd0);
        @(negedge clk);
        drive(1'b1, 5'd13, 32'hD, 1'b1, 5'd12, 32'hC, 5'd11, 5'd0);
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd11, 5'd0);
        #1 chk("three_queued", pk(1'b0, 1'b1, 5'd11, 32'hB, 1'b1, 32'hB, 1'b0, 32'h0, 1'b1));
        #2 rst = 1'b0;
        #1 chk("async_reset", pk(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0));
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 chk($sformatf("post_reset_idle%0d", i), pk(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0));
        end

        // wrap-around: ten back-to-back single writes through a 4-entry queue
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            drive(1'b1, 5'(i), 32'(32'h100 + i), 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
            #1 chk($sformatf("wrap%0d", i), (i > 1) ? pk(1'b1, 1'b1, 5'(i - 1), 32'(32'h100 + i - 1), 1'b0, 32'h0, 1'b0, 32'h0, 1'b0)
                                                    : pk(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0));
        end
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd10, 5'd0);
        #1 chk("wrap_last", pk(1'b1, 1'b1, 5'd10, 32'h10A, 1'b1, 32'h10A, 1'b0, 32'h0, 1'b0));
        @(negedge clk);
        #1 chk("wrap_empty", pk(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
